// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, code constants and the character table.
package morse_pkg;

    localparam int CODE_W = 6;
    localparam int LEN_W  = 3;
    localparam int ELEM_W = 5;

    localparam logic [CODE_W-1:0] CODE_SPACE     = 6'd36;
    localparam logic [CODE_W-1:0] CODE_LAST_CHAR = 6'd35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_ELEM_GAP,
        ST_CHAR_GAP,
        ST_WORD_GAP
    } morse_state_e;

    // len = number of elements (0 = no pattern); elems bit i = element i, 1 = dash.
    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ELEM_W-1:0] elems;
    } morse_pat_t;

    function automatic morse_pat_t morse_lookup(input logic [CODE_W-1:0] code);
        morse_pat_t p;
        case (code)
            6'd0:  p = {3'd2, 5'b00010}; // A .-
            6'd1:  p = {3'd4, 5'b00001}; // B -...
            6'd2:  p = {3'd4, 5'b00101}; // C -.-.
            6'd3:  p = {3'd3, 5'b00001}; // D -..
            6'd4:  p = {3'd1, 5'b00000}; // E .
            6'd5:  p = {3'd4, 5'b00100}; // F ..-.
            6'd6:  p = {3'd3, 5'b00011}; // G --.
            6'd7:  p = {3'd4, 5'b00000}; // H ....
            6'd8:  p = {3'd2, 5'b00000}; // I ..
            6'd9:  p = {3'd4, 5'b01110}; // J .---
            6'd10: p = {3'd3, 5'b00101}; // K -.-
            6'd11: p = {3'd4, 5'b00010}; // L .-..
            6'd12: p = {3'd2, 5'b00011}; // M --
            6'd13: p = {3'd2, 5'b00001}; // N -.
            6'd14: p = {3'd3, 5'b00111}; // O ---
            6'd15: p = {3'd4, 5'b00110}; // P .--.
            6'd16: p = {3'd4, 5'b01011}; // Q --.-
            6'd17: p = {3'd3, 5'b00010}; // R .-.
            6'd18: p = {3'd3, 5'b00000}; // S ...
            6'd19: p = {3'd1, 5'b00001}; // T -
            6'd20: p = {3'd3, 5'b00100}; // U ..-
            6'd21: p = {3'd4, 5'b01000}; // V ...-
            6'd22: p = {3'd3, 5'b00110}; // W .--
            6'd23: p = {3'd4, 5'b01001}; // X -..-
            6'd24: p = {3'd4, 5'b01101}; // Y -.--
            6'd25: p = {3'd4, 5'b00011}; // Z --..
            6'd26: p = {3'd5, 5'b11111}; // 0 -----
            6'd27: p = {3'd5, 5'b11110}; // 1 .----
            6'd28: p = {3'd5, 5'b11100}; // 2 ..---
            6'd29: p = {3'd5, 5'b11000}; // 3 ...--
            6'd30: p = {3'd5, 5'b10000}; // 4 ....-
            6'd31: p = {3'd5, 5'b00000}; // 5 .....
            6'd32: p = {3'd5, 5'b00001}; // 6 -....
            6'd33: p = {3'd5, 5'b00011}; // 7 --...
            6'd34: p = {3'd5, 5'b00111}; // 8 ---..
            6'd35: p = {3'd5, 5'b01111}; // 9 ----.
            default: p = '0;            // word space and invalid codes carry no pattern
        endcase
        return p;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse unit timer: divides clk into units of DOT_CYCLES and counts units within a state.
module morse_unit_timer
    import morse_pkg::*;
#(
    parameter int DOT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       clear,
    output logic       unit_tick,
    output logic [1:0] unit_cnt
);

    localparam int CNT_W = (DOT_CYCLES > 1) ? $clog2(DOT_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       units_q, units_d;
    logic             wrap;

    assign wrap      = (cnt_q == CNT_W'(DOT_CYCLES - 1));
    assign unit_tick = ena && wrap;
    assign unit_cnt  = units_q;

    // Next count: restart on clear, otherwise wrap each unit and bump the unit count.
    always_comb begin
        cnt_d   = cnt_q;
        units_d = units_q;
        if (clear) begin
            cnt_d   = '0;
            units_d = '0;
        end else if (wrap) begin
            cnt_d   = '0;
            units_d = units_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, frozen while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            units_q <= '0;
        end else if (ena) begin
            cnt_q   <= cnt_d;
            units_q <= units_d;
        end
    end

endmodule

// File: rtl/morse_char_encoder.sv
// Morse character encoder: keys one accepted character code out as timed marks and spaces.
module morse_char_encoder
    import morse_pkg::*;
#(
    parameter int DOT_CYCLES = 10000,
    parameter int TONE_DIV   = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              in_ready,
    output logic              key_out,
    output logic              tone_out,
    output logic              busy,
    output logic              err
);

    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    morse_state_e      state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ELEM_W-1:0] elems_q, elems_d;
    logic              key_out_q, key_out_d;
    logic              err_q, err_d;
    logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
    logic              tone_ph_q, tone_ph_d;

    morse_pat_t pat;
    logic       accept;
    logic       unit_tick;
    logic [1:0] unit_cnt;
    logic [1:0] mark_last;
    logic       timer_clear;

    assign pat         = morse_lookup(in_code);
    assign in_ready    = (state_q == ST_IDLE);
    assign accept      = in_valid && in_ready && ena;
    assign mark_last   = elems_q[0] ? 2'd2 : 2'd0;
    assign timer_clear = (state_d != state_q) || (state_q == ST_IDLE);

    assign key_out  = key_out_q;
    assign tone_out = key_out_q & tone_ph_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

    morse_unit_timer #(
        .DOT_CYCLES (DOT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .clear     (timer_clear),
        .unit_tick (unit_tick),
        .unit_cnt  (unit_cnt)
    );

    // Next state, element shift and error pulse; key_out follows the next state so it is registered.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        elems_d = elems_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_code == CODE_SPACE) begin
                        state_d = ST_WORD_GAP;
                    end else if (in_code <= CODE_LAST_CHAR) begin
                        state_d = ST_MARK;
                        len_d   = pat.len;
                        elems_d = pat.elems;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_MARK: begin
                if (unit_tick && (unit_cnt == mark_last)) begin
                    if (len_q > 3'd1) begin
                        state_d = ST_ELEM_GAP;
                        len_d   = len_q - 3'd1;
                        elems_d = elems_q >> 1;
                    end else begin
                        state_d = ST_CHAR_GAP;
                    end
                end
            end
            ST_ELEM_GAP: begin
                if (unit_tick && (unit_cnt == 2'd0)) state_d = ST_MARK;
            end
            ST_CHAR_GAP: begin
                if (unit_tick && (unit_cnt == 2'd2)) state_d = ST_IDLE;
            end
            ST_WORD_GAP: begin
                if (unit_tick && (unit_cnt == 2'd3)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        key_out_d = (state_d == ST_MARK);
    end

    // Free-running sidetone divider; phase flips once per TONE_DIV enabled cycles.
    always_comb begin
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
        tone_ph_d  = tone_ph_q;
        if (tone_cnt_q == TONE_W'(TONE_DIV - 1)) begin
            tone_cnt_d = '0;
            tone_ph_d  = ~tone_ph_q;
        end
    end

    // Control registers: reset wins, otherwise everything holds while ena is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            key_out_q  <= 1'b0;
            err_q      <= 1'b0;
            tone_cnt_q <= '0;
            tone_ph_q  <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            len_q      <= len_d;
            key_out_q  <= key_out_d;
            err_q      <= err_d;
            tone_cnt_q <= tone_cnt_d;
            tone_ph_q  <= tone_ph_d;
        end
    end

    // Element shift register holds pattern data only and is qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ena) begin
            elems_q <= elems_d;
        end
    end

endmodule
